// File: rtl/mem_responder.sv
// Word-addressed RAM that answers one request at a time after WAIT_CYCLES wait states,
// then pulses ready with read data or an error flag for misaligned/out-of-range addresses.
module mem_responder #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              addr_bad;
    logic              commit;

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    endfunction

    assign idx      = addr_q[ADDR_W+1:2];
    assign addr_bad = bad_addr(addr_q);
    assign commit   = (state == BUSY) && (cnt == 4'd0);

    // Request capture: data only, so no reset needed
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Gate on reset so a write interrupted in BUSY never lands
    always_ff @(posedge clk) begin
        if (reset && commit && we_q && !addr_bad) begin
            mem[idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'd0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= BUSY;
                        cnt   <= 4'(WAIT_CYCLES);
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= DONE;
                        ready <= 1'b1;
                        err   <= addr_bad;
                        rdata <= (we_q || addr_bad) ? 32'd0 : mem[idx];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance for the main cases and a
// WAIT_CYCLES=0 instance for zero-wait latency and back-to-back throughput.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy0, ready0, err0;
    logic        busy1, ready1, err1;
    logic [31:0] rdata0, rdata1;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy0), .ready(ready0), .rdata(rdata0), .err(err0)
    );

    mem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy1), .ready(ready1), .rdata(rdata1), .err(err1)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input bit s);
        return s ? ready1 : ready0;
    endfunction

    function automatic logic bsy(input bit s);
        return s ? busy1 : busy0;
    endfunction

    // Called just after a rising edge (cycle 0); returns just after the edge of the cycle after DONE
    task automatic txn(input bit s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                       input string name);
        int          lat;
        logic        e;
        logic [31:0] r;
        lat = -1;
        e   = 1'bx;
        r   = 'x;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (c == 1) check({name, " busy_c1"}, 32'(bsy(s)), 32'd1);
            if (rdy(s)) begin
                lat = c;
                e   = s ? err1 : err0;
                r   = s ? rdata1 : rdata0;
                check({name, " busy_done"}, 32'(bsy(s)), 32'd1);
                break;
            end
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " err"}, 32'(e), 32'(exp_err));
        check({name, " rdata"}, r, exp_rd);
        @(posedge clk); #1;
        check({name, " ready_single"}, 32'(rdy(s)), 32'd0);
        check({name, " busy_after"}, 32'(bsy(s)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rc[3];
        logic [31:0] rv[3];
        logic seen;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0011, 32'h1234_5678, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[5]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_0001, 1'b0, 32'h0000_0000};
        vecs[6]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 1'b0, 32'hA5A5_0001};
        vecs[7]  = '{1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0, 32'h0000_0000};
        vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h1111_2222};
        vecs[9]  = '{1'b1, 32'h0000_0102, 32'h7777_7777, 1'b1, 32'h0000_0000};
        vecs[10] = '{1'b0, 32'h0000_0003, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000};

        reset = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        #1;
        check("rst busy0", 32'(busy0), 32'd0);
        check("rst ready0", 32'(ready0), 32'd0);
        check("rst err0", 32'(err0), 32'd0);
        check("rst rdata0", rdata0, 32'd0);
        check("rst busy1", 32'(busy1), 32'd0);
        check("rst ready1", 32'(ready1), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            txn(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, 4, vecs[i].err, vecs[i].rdata,
                $sformatf("vec%0d", i));
        end

        // Reset while BUSY: write to 0x20 must be dropped, no ready
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("midrst busy_before", 32'(busy0), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst busy_now", 32'(busy0), 32'd0);
        check("midrst ready_now", 32'(ready0), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ready0) seen = 1'b1;
        end
        check("midrst no_ready", 32'(seen), 32'd0);
        txn(1'b0, 1'b0, 32'h20, 32'd0, 4, 1'b0, 32'h1111_2222, "midrst mem_kept");

        // Held req with inputs changing every cycle
        txn(1'b0, 1'b1, 32'h44, 32'h4444_4444, 4, 1'b0, 32'd0, "pre44");
        repeat (2) @(posedge clk);
        #1;
        n = 0;
        rc[0] = -1; rc[1] = -1; rc[2] = -1;
        req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hB000_0000;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); #1;
            if (ready0) begin
                if (n < 3) rc[n] = c;
                n++;
            end
            req   = (c < 15);
            addr  = 32'h40 + 32'(4 * c);
            wdata = 32'hB000_0000 + 32'(c);
        end
        req = 1'b0;
        check("held count", n, 3);
        check("held ready0_cycle", rc[0], 4);
        check("held ready1_cycle", rc[1], 9);
        check("held ready2_cycle", rc[2], 14);
        repeat (3) @(posedge clk);
        #1;
        txn(1'b0, 1'b0, 32'h40, 32'd0, 4, 1'b0, 32'hB000_0000, "held rd40");
        txn(1'b0, 1'b0, 32'h54, 32'd0, 4, 1'b0, 32'hB000_0005, "held rd54");
        txn(1'b0, 1'b0, 32'h68, 32'd0, 4, 1'b0, 32'hB000_000A, "held rd68");
        txn(1'b0, 1'b0, 32'h44, 32'd0, 4, 1'b0, 32'h4444_4444, "held rd44");

        // Zero-wait instance
        repeat (3) @(posedge clk);
        #1;
        txn(1'b1, 1'b1, 32'h08, 32'h600D_0008, 2, 1'b0, 32'd0, "w0 write");
        repeat (3) @(posedge clk);
        #1;
        txn(1'b1, 1'b0, 32'h08, 32'd0, 2, 1'b0, 32'h600D_0008, "w0 read");
        repeat (3) @(posedge clk);
        #1;
        n = 0;
        rc[0] = -1; rc[1] = -1; rc[2] = -1;
        rv[0] = 32'd0; rv[1] = 32'd0; rv[2] = 32'd0;
        req = 1'b1; we = 1'b0; addr = 32'h08;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (ready1) begin
                if (n < 3) begin
                    rc[n] = c;
                    rv[n] = rdata1;
                end
                n++;
            end
            req = (c < 7);
        end
        req = 1'b0;
        check("w0 b2b count", n, 3);
        check("w0 b2b ready_a", rc[0], 2);
        check("w0 b2b ready_b", rc[1], 5);
        check("w0 b2b ready_c", rc[2], 8);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("w0 b2b rdata%0d", i), rv[i], 32'h600D_0008);
        end

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
